instruction_cache: RTL and testbench

//  Direct-mapped, read-only instruction cache between cpu fetch port (PC/INSTRUCTION/INSTR_MEM_BUSYWAIT) and instruction memory.
//  Hit: instruction returned same cycle, no stall. Miss: stalls cpu, fetches one 128-bit block, refills, then hits.

---
 rtl/instruction_cache_pkg.sv | 25 ++
 rtl/instruction_cache_if.sv | 24 ++
 rtl/instruction_cache_data_array.sv | 42 ++++
 rtl/instruction_cache.sv | 121 ++++++++++++
 tb/tb_instruction_cache.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_cache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package instruction_cache_pkg;

    localparam int NUM_BLOCKS      = 8;
    localparam int INDEX_W         = $clog2(NUM_BLOCKS);
    localparam int WORDS_PER_BLOCK = 4;
    localparam int TAG_W           = 32 - INDEX_W - 4;
    localparam int BLOCK_W         = 32 * WORDS_PER_BLOCK;
    localparam int MADDR_W         = TAG_W + INDEX_W;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [TAG_W-1:0]   tag_t;
    typedef logic [INDEX_W-1:0] index_t;
    typedef logic [BLOCK_W-1:0] block_t;

    function automatic logic [31:0] block_word(block_t b, logic [1:0] w);
        return b[32*w +: 32];
    endfunction

endpackage

// File: rtl/instruction_cache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
interface instruction_cache_if;
    import instruction_cache_pkg::*;

    logic [31:0]        ADDRESS;
    logic               INVALIDATE;
    logic [31:0]        INSTRUCTION;
    logic               BUSYWAIT;
    logic               MEM_READ;
    logic [MADDR_W-1:0] MEM_ADDRESS;
    block_t             MEM_READDATA;
    logic               MEM_BUSYWAIT;

    modport slave (
        input  ADDRESS, INVALIDATE, MEM_READDATA, MEM_BUSYWAIT,
        output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );

    modport master (
        output ADDRESS, INVALIDATE, MEM_READDATA, MEM_BUSYWAIT,
        input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );

endinterface

// File: rtl/instruction_cache_data_array.sv
// Valid/tag/data storage: async read by index, sync line write, sync clear-all.
module icache_data_array
    import instruction_cache_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   clear_i,
    input  logic   we_i,
    input  index_t rd_index_i,
    input  index_t wr_index_i,
    input  tag_t   wr_tag_i,
    input  block_t wr_data_i,
    output logic   valid_o,
    output tag_t   tag_o,
    output block_t data_o
);

    logic [NUM_BLOCKS-1:0] valid_q;
    tag_t                  tag_q  [NUM_BLOCKS];
    block_t                data_q [NUM_BLOCKS];

    // Clear wins over a same-edge fill so a pending fence.i drops the new line too.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_data_i;
        end
    end

    assign valid_o = valid_q[rd_index_i];
    assign tag_o   = tag_q[rd_index_i];
    assign data_o  = data_q[rd_index_i];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: lookup, miss FSM, counters.
module instruction_cache
    import instruction_cache_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    instruction_cache_if.slave  bus,
    output logic [31:0]         HIT_COUNT,
    output logic [31:0]         MISS_COUNT
);

    logic [1:0]         state_q, state_d;
    logic               mem_read_q, mem_read_d;
    logic [MADDR_W-1:0] mem_addr_q, mem_addr_d;
    block_t             fill_q, fill_d;
    logic               inval_pending_q, inval_pending_d;
    logic [31:0]        hit_cnt_q, hit_cnt_d;
    logic [31:0]        miss_cnt_q, miss_cnt_d;

    tag_t       addr_tag;
    index_t     addr_idx;
    logic [1:0] addr_word;
    logic       line_valid;
    tag_t       line_tag;
    block_t     line_data;
    logic       hit;
    logic       clear_all;
    logic       line_we;

    assign addr_tag  = bus.ADDRESS[31:7];
    assign addr_idx  = bus.ADDRESS[6:4];
    assign addr_word = bus.ADDRESS[3:2];

    assign hit = (state_q == ST_IDLE) && !RESET && line_valid
                 && (line_tag == addr_tag);

    assign clear_all = ((state_q == ST_IDLE) && bus.INVALIDATE)
                    || ((state_q == ST_UPDATE)
                        && (inval_pending_q || bus.INVALIDATE));
    assign line_we   = (state_q == ST_UPDATE) && !RESET;

    icache_data_array u_array (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .clear_i    (clear_all),
        .we_i       (line_we),
        .rd_index_i (addr_idx),
        .wr_index_i (mem_addr_q[INDEX_W-1:0]),
        .wr_tag_i   (mem_addr_q[MADDR_W-1:INDEX_W]),
        .wr_data_i  (fill_q),
        .valid_o    (line_valid),
        .tag_o      (line_tag),
        .data_o     (line_data)
    );

    assign bus.INSTRUCTION = hit ? block_word(line_data, addr_word) : NOP_INSTR;
    assign bus.BUSYWAIT    = !RESET && !hit;
    assign bus.MEM_READ    = mem_read_q;
    assign bus.MEM_ADDRESS = mem_addr_q;
    assign HIT_COUNT       = hit_cnt_q;
    assign MISS_COUNT      = miss_cnt_q;

    always_comb begin
        state_d         = state_q;
        mem_read_d      = mem_read_q;
        mem_addr_d      = mem_addr_q;
        fill_d          = fill_q;
        inval_pending_d = inval_pending_q;
        hit_cnt_d       = hit_cnt_q;
        miss_cnt_d      = miss_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    hit_cnt_d = hit_cnt_q + 32'd1;
                end else begin
                    mem_addr_d = {addr_tag, addr_idx};
                    mem_read_d = 1'b1;
                    miss_cnt_d = miss_cnt_q + 32'd1;
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                inval_pending_d = inval_pending_q || bus.INVALIDATE;
                if (!bus.MEM_BUSYWAIT) begin
                    fill_d     = bus.MEM_READDATA;
                    mem_read_d = 1'b0;
                    state_d    = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                inval_pending_d = 1'b0;
                state_d         = ST_IDLE;
            end
            default: begin
                mem_read_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q         <= ST_IDLE;
            mem_read_q      <= 1'b0;
            mem_addr_q      <= '0;
            fill_q          <= '0;
            inval_pending_q <= 1'b0;
            hit_cnt_q       <= '0;
            miss_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            mem_read_q      <= mem_read_d;
            mem_addr_q      <= mem_addr_d;
            fill_q          <= fill_d;
            inval_pending_q <= inval_pending_d;
            hit_cnt_q       <= hit_cnt_d;
            miss_cnt_q      <= miss_cnt_d;
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Scenario bench for instruction_cache against a line-level cache model.
module tb_instruction_cache;
    import instruction_cache_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] hit_count, miss_count;
    always #5 clk = ~clk;

    instruction_cache_if bus ();

    instruction_cache dut (
        .CLK        (clk),
        .RESET      (rst),
        .bus        (bus.slave),
        .HIT_COUNT  (hit_count),
        .MISS_COUNT (miss_count)
    );

    int checks = 0;
    int errors = 0;

    // Backing memory: each word is a fixed scramble of its own address.
    int lat = 5;
    int mcnt = 0;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    always @(posedge clk) begin
        if (!bus.MEM_READ || !bus.MEM_BUSYWAIT) mcnt <= 0;
        else mcnt <= mcnt + 1;
    end

    assign bus.MEM_BUSYWAIT = bus.MEM_READ ? (mcnt != lat - 1) : 1'b0;
    assign bus.MEM_READDATA = {mem_word({bus.MEM_ADDRESS, 4'hC}),
                               mem_word({bus.MEM_ADDRESS, 4'h8}),
                               mem_word({bus.MEM_ADDRESS, 4'h4}),
                               mem_word({bus.MEM_ADDRESS, 4'h0})};

    // Reference model: which block address each line currently holds.
    bit          mv [8];
    logic [24:0] mt [8];
    int          exp_hits = 0;
    int          exp_misses = 0;

    function automatic bit model_hit(logic [31:0] a);
        return mv[a[6:4]] && (mt[a[6:4]] == a[31:7]);
    endfunction

    task automatic model_fill(input logic [31:0] a);
        mv[a[6:4]] = 1'b1;
        mt[a[6:4]] = a[31:7];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mv[i] = 1'b0;
    endtask

    task automatic fetch_line(input logic [31:0] a, output logic [31:0] instr,
                              output int stall, output int nreq,
                              output logic [27:0] maddr);
        bus.ADDRESS = a;
        stall = 0;
        nreq = 0;
        maddr = '0;
        @(negedge clk);
        while (bus.BUSYWAIT && stall < 64) begin
            if (bus.MEM_READ) begin
                nreq++;
                maddr = bus.MEM_ADDRESS;
            end
            stall++;
            @(negedge clk);
        end
        instr = bus.INSTRUCTION;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ADDRESS = 32'h0;
        bus.INVALIDATE = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.BUSYWAIT !== 1'b0 || bus.MEM_READ !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b rd=%b expected 0 0",
                     bus.BUSYWAIT, bus.MEM_READ);
        end
        checks++;
        if (bus.MEM_ADDRESS !== 28'h0 || bus.INSTRUCTION !== 32'h13) begin
            errors++;
            $display("FAIL reset_out: maddr=%h instr=%h expected 0 00000013",
                     bus.MEM_ADDRESS, bus.INSTRUCTION);
        end
        checks++;
        if (hit_count !== 0 || miss_count !== 0) begin
            errors++;
            $display("FAIL reset_cnt: hit=%0d miss=%0d expected 0 0",
                     hit_count, miss_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        exp_hits = 0;
        exp_misses = 0;
    endtask

    task automatic test_cold_miss();
        logic [31:0] instr;
        logic [27:0] maddr;
        int stall, nreq;
        lat = 5;
        fetch_line(32'h0, instr, stall, nreq, maddr);
        model_fill(32'h0);
        exp_misses++;
        exp_hits++;
        checks++;
        if (stall !== 7 || nreq !== 5) begin
            errors++;
            $display("FAIL cold_stall: stall=%0d req=%0d expected 7 5",
                     stall, nreq);
        end
        checks++;
        if (maddr !== 28'h0 || instr !== mem_word(32'h0)) begin
            errors++;
            $display("FAIL cold_data: maddr=%h instr=%h expected 0 %h",
                     maddr, instr, mem_word(32'h0));
        end
        checks++;
        if (miss_count !== exp_misses || hit_count !== exp_hits) begin
            errors++;
            $display("FAIL cold_cnt: miss=%0d hit=%0d expected %0d %0d",
                     miss_count, hit_count, exp_misses, exp_hits);
        end
    endtask

    task automatic test_spatial();
        logic [31:0] instr;
        logic [27:0] maddr;
        int stall, nreq;
        for (int i = 1; i < 4; i++) begin
            fetch_line(32'(i * 4), instr, stall, nreq, maddr);
            exp_hits++;
            checks++;
            if (stall !== 0 || nreq !== 0 || instr !== mem_word(32'(i * 4))) begin
                errors++;
                $display("FAIL spatial_w%0d: stall=%0d req=%0d instr=%h expected 0 0 %h",
                         i, stall, nreq, instr, mem_word(32'(i * 4)));
            end
        end
        checks++;
        if (hit_count !== exp_hits || miss_count !== exp_misses) begin
            errors++;
            $display("FAIL spatial_cnt: hit=%0d miss=%0d expected %0d %0d",
                     hit_count, miss_count, exp_hits, exp_misses);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] instr;
        logic [27:0] maddr;
        int stall, nreq;
        fetch_line(32'h80, instr, stall, nreq, maddr);
        model_fill(32'h80);
        exp_misses++;
        exp_hits++;
        checks++;
        if (stall !== lat + 2 || maddr !== 28'h8 || instr !== mem_word(32'h80)) begin
            errors++;
            $display("FAIL conflict_a: stall=%0d maddr=%h instr=%h expected %0d 8 %h",
                     stall, maddr, instr, lat + 2, mem_word(32'h80));
        end
        fetch_line(32'h0, instr, stall, nreq, maddr);
        model_fill(32'h0);
        exp_misses++;
        exp_hits++;
        checks++;
        if (stall !== lat + 2 || maddr !== 28'h0 || instr !== mem_word(32'h0)) begin
            errors++;
            $display("FAIL conflict_b: stall=%0d maddr=%h instr=%h expected %0d 0 %h",
                     stall, maddr, instr, lat + 2, mem_word(32'h0));
        end
        checks++;
        if (miss_count !== 3 || miss_count !== exp_misses) begin
            errors++;
            $display("FAIL conflict_cnt: miss=%0d expected 3", miss_count);
        end
    endtask

    task automatic test_invalidate();
        logic [31:0] instr;
        logic [27:0] maddr;
        int stall, nreq, n;
        fetch_line(32'h10, instr, stall, nreq, maddr);
        model_fill(32'h10);
        exp_misses++;
        exp_hits++;
        bus.INVALIDATE = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.BUSYWAIT !== 1'b0) begin
            errors++;
            $display("FAIL inval_idle_hit: busy=%b expected 0", bus.BUSYWAIT);
        end
        @(posedge clk);
        #1;
        bus.INVALIDATE = 1'b0;
        model_clear();
        exp_hits++;
        fetch_line(32'h10, instr, stall, nreq, maddr);
        model_fill(32'h10);
        exp_misses++;
        exp_hits++;
        checks++;
        if (stall !== lat + 2 || instr !== mem_word(32'h10)) begin
            errors++;
            $display("FAIL inval_idle_refetch: stall=%0d instr=%h expected %0d %h",
                     stall, instr, lat + 2, mem_word(32'h10));
        end
        bus.ADDRESS = 32'h20;
        @(posedge clk);
        #1;
        exp_misses++;
        bus.INVALIDATE = 1'b1;
        @(posedge clk);
        #1;
        bus.INVALIDATE = 1'b0;
        n = 0;
        while (bus.MEM_READ && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        model_clear();
        fetch_line(32'h20, instr, stall, nreq, maddr);
        model_fill(32'h20);
        exp_misses++;
        exp_hits++;
        checks++;
        if (stall !== lat + 2 || maddr !== 28'h2 || instr !== mem_word(32'h20)) begin
            errors++;
            $display("FAIL inval_fetch_refetch: stall=%0d maddr=%h instr=%h expected %0d 2 %h",
                     stall, maddr, instr, lat + 2, mem_word(32'h20));
        end
        checks++;
        if (miss_count !== exp_misses || hit_count !== exp_hits) begin
            errors++;
            $display("FAIL inval_cnt: miss=%0d hit=%0d expected %0d %0d",
                     miss_count, hit_count, exp_misses, exp_hits);
        end
    endtask

    task automatic test_addr_change();
        logic [27:0] maddr;
        int n, nreq;
        bus.ADDRESS = 32'h40;
        @(posedge clk);
        #1;
        bus.ADDRESS = 32'h4C;
        n = 0;
        nreq = 0;
        maddr = '0;
        @(negedge clk);
        while (bus.BUSYWAIT && n < 64) begin
            if (bus.MEM_READ) begin
                nreq++;
                maddr = bus.MEM_ADDRESS;
            end
            n++;
            @(negedge clk);
        end
        checks++;
        if (maddr !== 28'h4 || n !== lat + 1 || nreq !== lat) begin
            errors++;
            $display("FAIL addr_change_fill: maddr=%h cyc=%0d req=%0d expected 4 %0d %0d",
                     maddr, n, nreq, lat + 1, lat);
        end
        checks++;
        if (bus.INSTRUCTION !== mem_word(32'h4C) || bus.MEM_READ !== 1'b0) begin
            errors++;
            $display("FAIL addr_change_hit: instr=%h rd=%b expected %h 0",
                     bus.INSTRUCTION, bus.MEM_READ, mem_word(32'h4C));
        end
        @(posedge clk);
        #1;
        model_fill(32'h40);
        exp_misses++;
        exp_hits++;
        checks++;
        if (miss_count !== exp_misses || hit_count !== exp_hits) begin
            errors++;
            $display("FAIL addr_change_cnt: miss=%0d hit=%0d expected %0d %0d",
                     miss_count, hit_count, exp_misses, exp_hits);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, instr;
        logic [27:0] maddr;
        int stall, nreq, bad;
        bit h;
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            lat = $urandom_range(1, 6);
            a = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 31) << 2);
            if ($urandom_range(0, 7) == 0) a[31:24] = 8'($urandom);
            h = model_hit(a);
            fetch_line(a, instr, stall, nreq, maddr);
            if (!h) begin
                model_fill(a);
                exp_misses++;
            end
            exp_hits++;
            checks++;
            if (instr !== mem_word(a) || stall !== (h ? 0 : lat + 2)
                || (!h && maddr !== a[31:4])) begin
                errors++;
                bad++;
                if (bad < 8)
                    $display("FAIL random_%0d: a=%h instr=%h stall=%0d maddr=%h expected %h %0d %h",
                             i, a, instr, stall, maddr, mem_word(a),
                             h ? 0 : lat + 2, a[31:4]);
            end
        end
        checks++;
        if (miss_count !== exp_misses || hit_count !== exp_hits) begin
            errors++;
            $display("FAIL random_cnt: miss=%0d hit=%0d expected %0d %0d",
                     miss_count, hit_count, exp_misses, exp_hits);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] instr;
        logic [27:0] maddr;
        int stall, nreq;
        lat = 5;
        bus.ADDRESS = 32'hABC0_0300;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (bus.MEM_READ !== 1'b0 || bus.BUSYWAIT !== 1'b0
            || bus.INSTRUCTION !== 32'h13) begin
            errors++;
            $display("FAIL midfill_reset: rd=%b busy=%b instr=%h expected 0 0 00000013",
                     bus.MEM_READ, bus.BUSYWAIT, bus.INSTRUCTION);
        end
        checks++;
        if (hit_count !== 0 || miss_count !== 0) begin
            errors++;
            $display("FAIL midfill_cnt: hit=%0d miss=%0d expected 0 0",
                     hit_count, miss_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        exp_hits = 0;
        exp_misses = 0;
        fetch_line(32'hABC0_0300, instr, stall, nreq, maddr);
        model_fill(32'hABC0_0300);
        exp_misses++;
        exp_hits++;
        checks++;
        if (stall !== lat + 2 || maddr !== 28'hABC0030
            || instr !== mem_word(32'hABC0_0300)) begin
            errors++;
            $display("FAIL midfill_refetch: stall=%0d maddr=%h instr=%h expected %0d abc0030 %h",
                     stall, maddr, instr, lat + 2, mem_word(32'hABC0_0300));
        end
        checks++;
        if (miss_count !== exp_misses || hit_count !== exp_hits) begin
            errors++;
            $display("FAIL midfill_cnt2: miss=%0d hit=%0d expected %0d %0d",
                     miss_count, hit_count, exp_misses, exp_hits);
        end
    endtask

    initial begin
        bus.ADDRESS = 32'h0;
        bus.INVALIDATE = 1'b0;
        rst = 1'b1;
        test_reset();
        test_cold_miss();
        test_spatial();
        test_conflict();
        test_invalidate();
        test_addr_change();
        test_random();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
